// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request bus between the MEM-stage controller
// and a multi-cycle data memory (req held until one-cycle ack).
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: issues one load/store per
// instruction, stalls upstream while busy, times out hangs.
module mem_stage_ctrl #(
  parameter int              DATA_W   = 16,
  parameter int              TO_MAX   = 255,
  parameter int              TO_W     = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_MemRead,
  input  logic              MEM_memwrite,
  input  logic              MEM_inval,
  input  logic [DATA_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_wdata,
  input  logic              err_clr,
  mem_stage_ctrl_if.master  bus,
  output logic              stall,
  output logic [DATA_W-1:0] MEM_rdata,
  output logic              rd_valid,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Counter holds completed BUSY cycles; the last
  // allowed one is entered with TO_MAX-1 already counted.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              we_q, we_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic [TO_W-1:0]   cnt_q, cnt_n;
  logic              err_q, err_n;
  logic              err_set;
  logic              acc;
  logic              req_c;
  logic              stall_c;
  logic              rv_c;

  assign acc = (MEM_MemRead | MEM_memwrite) & ~MEM_inval;

  // Next-state, datapath capture and combinational outputs
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    we_n    = we_q;
    rdata_n = rdata_q;
    cnt_n   = cnt_q;
    err_set = 1'b0;
    req_c   = 1'b0;
    stall_c = 1'b0;
    rv_c    = 1'b0;
    unique case (state)
      IDLE: begin
        stall_c = acc;
        if (bus.mem_ack) err_set = 1'b1;
        if (acc) begin
          addr_n  = MEM_addr;
          wdata_n = MEM_wdata;
          we_n    = MEM_memwrite;
          if (MEM_MemRead && MEM_memwrite)
            err_set = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          if (!we_q) rdata_n = bus.mem_rdata;
          cnt_n   = '0;
          state_n = DONE;
        end else if (cnt_q == TO_LAST) begin
          if (!we_q) rdata_n = ERR_DATA;
          err_set = 1'b1;
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        rv_c = ~we_q;
        if (bus.mem_ack) err_set = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    err_n = err_set | (err_q & ~err_clr);
  end

  // State and datapath registers; reset abandons any access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      we_q    <= we_n;
      rdata_q <= rdata_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
    end
  end

  assign bus.mem_req   = req_c;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign stall         = stall_c;
  assign MEM_rdata     = rdata_q;
  assign rd_valid      = rv_c;
  assign err           = err_q;

endmodule
